// File: rtl/nonce_sweep_ctrl.sv
// Nonce sweep controller: fans a block header out to NUM_CORES hash cores,
// walks the nonce range in rounds and reports hashes at or below target.
module nonce_sweep_ctrl #(
    parameter int NUM_CORES    = 4,
    parameter int STOP_ON_FIND = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     job_valid,
    output logic                     job_ready,
    input  logic [607:0]             job_header,
    input  logic [255:0]             job_target,
    input  logic [31:0]              nonce_start,
    input  logic [31:0]              nonce_end,
    input  logic                     abort,
    output logic [NUM_CORES-1:0]     core_start,
    output logic [640*NUM_CORES-1:0] core_header,
    input  logic [NUM_CORES-1:0]     core_done,
    input  logic [256*NUM_CORES-1:0] core_hash,
    output logic                     found_valid,
    input  logic                     found_ready,
    output logic [31:0]              found_nonce,
    output logic [255:0]             found_hash,
    output logic                     sweep_done,
    output logic                     busy,
    output logic [31:0]              hash_count
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] ISSUE  = 3'd1;
    localparam logic [2:0] WAIT   = 3'd2;
    localparam logic [2:0] CHECK  = 3'd3;
    localparam logic [2:0] REPORT = 3'd4;
    localparam logic [2:0] FINISH = 3'd5;

    logic [2:0]           state;
    logic [607:0]         hdr_q;
    logic [255:0]         target_q;
    logic [31:0]          end_q;
    logic [32:0]          next_nonce;
    logic [NUM_CORES-1:0] active;
    logic [NUM_CORES-1:0] done_q;
    logic [255:0]         hash_q [NUM_CORES];
    logic [4:0]           scan_idx;
    logic                 last_q;

    logic [255:0] sel_hash;
    logic [255:0] sel_rev;
    logic [31:0]  sel_nonce;
    logic         last_w;
    logic         hit_w;
    logic         all_done;
    logic [32:0]  nn_step;
    logic         finish_w;

    // 33-bit compare keeps a sweep ending at 0xFFFFFFFF from wrapping
    always_comb begin
        for (int i = 0; i < NUM_CORES; i++)
            active[i] = (next_nonce + 33'(i)) <= {1'b0, end_q};
    end

    for (genvar g = 0; g < NUM_CORES; g++) begin : g_core
        logic [31:0] n;
        assign n = next_nonce[31:0] + 32'(g);
        assign core_header[640*g +: 640] =
            {hdr_q, n[7:0], n[15:8], n[23:16], n[31:24]};
    end

    assign core_start = (state == ISSUE && !abort) ? active : '0;
    assign job_ready  = (state == IDLE);
    assign busy       = (state != IDLE);
    assign sweep_done = (state == FINISH) && !abort;

    always_comb begin
        sel_hash  = '0;
        sel_nonce = '0;
        last_w    = 1'b1;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (scan_idx == 5'(i)) begin
                sel_hash  = hash_q[i];
                sel_nonce = next_nonce[31:0] + 32'(i);
            end
        end
        // active cores are contiguous from 0, so the first idle one ends the scan
        for (int i = 0; i < NUM_CORES - 1; i++)
            if (scan_idx == 5'(i))
                last_w = !active[i + 1];
        for (int k = 0; k < 32; k++)
            sel_rev[8*k +: 8] = sel_hash[255-8*k -: 8];
        hit_w    = sel_rev <= target_q;
        all_done = (done_q & active) == active;
        nn_step  = next_nonce + 33'(NUM_CORES);
        finish_w = nn_step > {1'b0, end_q};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            hdr_q       <= '0;
            target_q    <= '0;
            end_q       <= '0;
            next_nonce  <= '0;
            done_q      <= '0;
            scan_idx    <= '0;
            last_q      <= 1'b0;
            found_valid <= 1'b0;
            found_nonce <= '0;
            found_hash  <= '0;
            hash_count  <= '0;
            for (int i = 0; i < NUM_CORES; i++)
                hash_q[i] <= '0;
        end else if (state != IDLE && abort) begin
            state       <= IDLE;
            found_valid <= 1'b0;
            done_q      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (job_valid) begin
                        hdr_q      <= job_header;
                        target_q   <= job_target;
                        end_q      <= nonce_end;
                        hash_count <= '0;
                        next_nonce <= {1'b0, nonce_start};
                        state <= (nonce_end < nonce_start) ? FINISH : ISSUE;
                    end
                end
                ISSUE: begin
                    done_q   <= '0;
                    scan_idx <= '0;
                    state    <= WAIT;
                end
                WAIT: begin
                    for (int i = 0; i < NUM_CORES; i++) begin
                        if (active[i] && core_done[i] && !done_q[i]) begin
                            done_q[i] <= 1'b1;
                            hash_q[i] <= core_hash[256*i +: 256];
                        end
                    end
                    if (all_done)
                        state <= CHECK;
                end
                CHECK: begin
                    if (hash_count != '1)
                        hash_count <= hash_count + 32'd1;
                    scan_idx <= scan_idx + 5'd1;
                    if (hit_w) begin
                        found_nonce <= sel_nonce;
                        found_hash  <= sel_hash;
                        found_valid <= 1'b1;
                        last_q      <= last_w;
                        state       <= REPORT;
                    end else if (last_w) begin
                        next_nonce <= nn_step;
                        state      <= finish_w ? FINISH : ISSUE;
                    end
                end
                REPORT: begin
                    if (found_ready) begin
                        found_valid <= 1'b0;
                        if (STOP_ON_FIND != 0) begin
                            state <= FINISH;
                        end else if (last_q) begin
                            next_nonce <= nn_step;
                            state      <= finish_w ? FINISH : ISSUE;
                        end else begin
                            state <= CHECK;
                        end
                    end
                end
                FINISH:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nonce_sweep_ctrl.sv
// Directed bench for nonce_sweep_ctrl: one stop-on-find and one
// report-all instance, each driven by a small fixed-latency core model.
module tb_nonce_sweep_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic [607:0] hdr;
    logic [255:0] tgt;
    logic [31:0]  ns, ne;

    logic          jv [2];
    logic          jr [2];
    logic          ab [2];
    logic          fr [2];
    logic          fv [2];
    logic          sd [2];
    logic          bsy [2];
    logic [3:0]    cs [2];
    logic [3:0]    cd [2];
    logic [2559:0] ch [2];
    logic [1023:0] chs [2] = '{default: '0};
    logic [31:0]   fn [2];
    logic [31:0]   hc [2];
    logic [255:0]  fh [2];

    int checks = 0;
    int failures = 0;

    nonce_sweep_ctrl #(.NUM_CORES(4), .STOP_ON_FIND(1)) dut_s (
        .clk(clk), .rst_n(rst_n),
        .job_valid(jv[0]), .job_ready(jr[0]),
        .job_header(hdr), .job_target(tgt),
        .nonce_start(ns), .nonce_end(ne), .abort(ab[0]),
        .core_start(cs[0]), .core_header(ch[0]),
        .core_done(cd[0]), .core_hash(chs[0]),
        .found_valid(fv[0]), .found_ready(fr[0]),
        .found_nonce(fn[0]), .found_hash(fh[0]),
        .sweep_done(sd[0]), .busy(bsy[0]), .hash_count(hc[0])
    );

    nonce_sweep_ctrl #(.NUM_CORES(4), .STOP_ON_FIND(0)) dut_m (
        .clk(clk), .rst_n(rst_n),
        .job_valid(jv[1]), .job_ready(jr[1]),
        .job_header(hdr), .job_target(tgt),
        .nonce_start(ns), .nonce_end(ne), .abort(ab[1]),
        .core_start(cs[1]), .core_header(ch[1]),
        .core_done(cd[1]), .core_hash(chs[1]),
        .found_valid(fv[1]), .found_ready(fr[1]),
        .found_nonce(fn[1]), .found_hash(fh[1]),
        .sweep_done(sd[1]), .busy(bsy[1]), .hash_count(hc[1])
    );

    bit          use_hits = 1'b0;
    logic [31:0] h0 = '0;
    logic [31:0] h1 = '0;

    function automatic logic [31:0] bswap32(input logic [31:0] v);
        return {v[7:0], v[15:8], v[23:16], v[31:24]};
    endfunction

    function automatic logic [255:0] bswap256(input logic [255:0] v);
        logic [255:0] r;
        for (int k = 0; k < 32; k++)
            r[8*k +: 8] = v[255-8*k -: 8];
        return r;
    endfunction

    // value the hit test compares against target, before byte reversal
    function automatic logic [255:0] rev_of(input logic [31:0] n);
        if (use_hits && (n == h0 || n == h1))
            return 256'h10;
        return (256'h1 << 200) | {224'd0, n};
    endfunction

    int          cnt [2][4];
    logic [31:0] cn  [2][4];

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 4; i++) begin
                cd[d][i] <= 1'b0;
                if (cs[d][i]) begin
                    cnt[d][i] = 3;
                    cn[d][i]  = bswap32(ch[d][640*i +: 32]);
                end else if (cnt[d][i] > 0) begin
                    cnt[d][i] = cnt[d][i] - 1;
                    if (cnt[d][i] == 0) begin
                        cd[d][i] <= 1'b1;
                        chs[d][256*i +: 256] <= bswap256(rev_of(cn[d][i]));
                    end
                end
            end
        end
    end

    int       rounds [2] = '{0, 0};
    int       sweeps [2] = '{0, 0};
    int       fvc    [2] = '{0, 0};
    logic [3:0] last_cs [2] = '{4'd0, 4'd0};

    always @(negedge clk) begin
        #1;
        for (int d = 0; d < 2; d++) begin
            if (cs[d] != 4'd0) begin
                rounds[d]  = rounds[d] + 1;
                last_cs[d] = cs[d];
            end
            if (sd[d] === 1'b1) sweeps[d] = sweeps[d] + 1;
            if (fv[d] === 1'b1) fvc[d] = fvc[d] + 1;
        end
    end

    task automatic chk(input string tag, input logic [255:0] obs,
                       input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic submit(input int d, input logic [31:0] s,
                          input logic [31:0] e, input logic [255:0] t,
                          input logic a);
        @(negedge clk);
        ns = s; ne = e; tgt = t;
        jv[d] = 1'b1; ab[d] = a;
        @(negedge clk);
        jv[d] = 1'b0; ab[d] = 1'b0;
        #1;
    endtask

    task automatic wait_for(input int d, input int which, input string tag);
        logic ok;
        ok = 1'b0;
        for (int c = 0; c < 300 && !ok; c++) begin
            @(negedge clk);
            #1;
            ok = (which == 0) ? fv[d] : sd[d];
        end
        chk(tag, {255'd0, ok}, 256'd1);
    endtask

    initial begin
        int r, s, f;
        hdr = {19{32'hA5C3_0F1E}};
        tgt = '0; ns = '0; ne = '0;
        for (int d = 0; d < 2; d++) begin
            jv[d] = 1'b0; ab[d] = 1'b0; fr[d] = 1'b0;
        end

        #2 rst_n = 1'b0;
        #1;
        chk("rst_job_ready", jr[0], 1);
        chk("rst_busy", bsy[0], 0);
        chk("rst_core_start", cs[0], 0);
        chk("rst_found_valid", fv[0], 0);
        chk("rst_sweep_done", sd[0], 0);
        chk("rst_hash_count", hc[0], 0);
        chk("rst_found_nonce", fn[0], 0);
        chk("rst_found_hash", fh[0], 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // every hash meets an all-ones target; first core wins
        submit(0, 32'd0, 32'd7, '1, 1'b0);
        chk("a_issue_cs", cs[0], 4'b1111);
        chk("a_busy", bsy[0], 1);
        chk("a_job_ready", jr[0], 0);
        chk("a_hdr_nonce1", ch[0][640 +: 32], 32'h0100_0000);
        chk("a_hdr_body", ch[0][672 +: 608] === hdr, 1);
        wait_for(0, 0, "a_found_to");
        chk("a_nonce", fn[0], 0);
        chk("a_hash", fh[0], bswap256(rev_of(32'd0)));
        chk("a_count", hc[0], 1);
        chk("a_no_early_done", sd[0], 0);
        fr[0] = 1'b1;
        wait_for(0, 1, "a_done_to");
        fr[0] = 1'b0;
        chk("a_fv_clear", fv[0], 0);
        chk("a_count_final", hc[0], 1);

        // target 0: nothing hits, three rounds, partial last round
        r = rounds[0]; f = fvc[0];
        submit(0, 32'd0, 32'd9, '0, 1'b0);
        wait_for(0, 1, "b_done_to");
        chk("b_rounds", 256'(rounds[0] - r), 3);
        chk("b_last_cs", last_cs[0], 4'b0011);
        chk("b_no_found", 256'(fvc[0] - f), 0);
        chk("b_count", hc[0], 10);

        // top of the nonce space: two cores, one round, no wrap
        r = rounds[0];
        submit(0, 32'hFFFF_FFFE, 32'hFFFF_FFFF, '0, 1'b0);
        chk("c_cs", cs[0], 4'b0011);
        chk("c_hdr_nonce0", ch[0][0 +: 32], 32'hFEFF_FFFF);
        chk("c_hdr_nonce1", ch[0][640 +: 32], 32'hFFFF_FFFF);
        wait_for(0, 1, "c_done_to");
        chk("c_rounds", 256'(rounds[0] - r), 1);
        chk("c_count", hc[0], 2);

        // empty range finishes straight away
        submit(0, 32'd5, 32'd3, '1, 1'b0);
        chk("e_empty_done", sd[0], 1);
        chk("e_empty_cs", cs[0], 0);
        chk("e_empty_count", hc[0], 0);

        // report-all instance; rev value 0x10 equals target exactly
        use_hits = 1'b1; h0 = 32'd2; h1 = 32'd5;
        s = sweeps[1];
        submit(1, 32'd0, 32'd7, 256'h10, 1'b0);
        wait_for(1, 0, "d_found1_to");
        chk("d_nonce1", fn[1], 2);
        chk("d_hash1", fh[1], bswap256(256'h10));
        chk("d_no_early_done", 256'(sweeps[1] - s), 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            chk("d_hold_valid", fv[1], 1);
            chk("d_hold_nonce", fn[1], 2);
        end
        fr[1] = 1'b1;
        @(negedge clk);
        #1;
        fr[1] = 1'b0;
        chk("d_hs_clear", fv[1], 0);
        wait_for(1, 0, "d_found2_to");
        chk("d_nonce2", fn[1], 5);
        chk("d_mid_no_done", 256'(sweeps[1] - s), 0);
        fr[1] = 1'b1;
        wait_for(1, 1, "d_done_to");
        fr[1] = 1'b0;
        chk("d_count", hc[1], 8);
        use_hits = 1'b0;

        // abort while cores are still busy
        s = sweeps[0]; f = fvc[0];
        submit(0, 32'd0, 32'd3, '1, 1'b0);
        @(negedge clk);
        #1;
        chk("e_wait_busy", bsy[0], 1);
        ab[0] = 1'b1;
        @(negedge clk);
        #1;
        ab[0] = 1'b0;
        chk("e_abort_idle", bsy[0], 0);
        chk("e_abort_ready", jr[0], 1);
        repeat (6) @(negedge clk);
        #1;
        chk("e_no_done", 256'(sweeps[0] - s), 0);
        chk("e_no_found", 256'(fvc[0] - f), 0);
        chk("e_still_idle", bsy[0], 0);

        // abort alongside job_valid in IDLE is ignored
        submit(0, 32'd4, 32'd7, '1, 1'b1);
        chk("f_accept_busy", bsy[0], 1);
        chk("f_cs", cs[0], 4'b1111);
        wait_for(0, 0, "f_found_to");
        chk("f_nonce", fn[0], 4);
        chk("f_count", hc[0], 1);
        fr[0] = 1'b1;
        wait_for(0, 1, "f_done_to");
        fr[0] = 1'b0;

        // reset while a hit is being reported
        submit(0, 32'd0, 32'd3, '1, 1'b0);
        wait_for(0, 0, "g_found_to");
        rst_n = 1'b0;
        #1;
        chk("g_rst_fv", fv[0], 0);
        chk("g_rst_busy", bsy[0], 0);
        chk("g_rst_ready", jr[0], 1);
        chk("g_rst_cs", cs[0], 0);
        chk("g_rst_sd", sd[0], 0);
        chk("g_rst_count", hc[0], 0);
        chk("g_rst_nonce", fn[0], 0);
        chk("g_rst_hash", fh[0], 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("g_post_ready", jr[0], 1);
        chk("g_post_busy", bsy[0], 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
